// File: rtl/sha2_pkg.sv
// SHA-2 message schedule: shared encodings, sizes and
// the load/emit state type.
package sha2_pkg;

    typedef enum logic [1:0] {
        SHA256 = 2'b00,
        SHA224 = 2'b01,
        SHA512 = 2'b10,
        SHA384 = 2'b11
    } sha_type_e;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_e;

    localparam int ROUNDS_32    = 64;
    localparam int ROUNDS_64    = 80;
    localparam int BLK_BITS_32  = 512;
    localparam int BLK_BITS_64  = 1024;
    localparam int WORD_BITS_32 = 32;
    localparam int WORD_BITS_64 = 64;
    localparam int BUF_WORDS    = 16;

    function automatic logic is_wide(input sha_type_e t);
        return (t == SHA512) || (t == SHA384);
    endfunction

endpackage

// File: rtl/wt_sched_gen_if.sv
// Stream bundles: block beats into the schedule unit
// and W_t words out to the round engine.
interface wt_blk_if #(
    parameter int DW = 512
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (
        output tdata, tvalid, tlast,
        input  tready
    );
    modport slave (
        input  tdata, tvalid, tlast,
        output tready
    );
endinterface

interface wt_word_if #(
    parameter int DW = 64,
    parameter int RW = 7
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          tmsglast;
    logic [RW-1:0] tround;

    modport master (
        output tdata, tvalid, tlast, tmsglast, tround,
        input  tready
    );
    modport slave (
        input  tdata, tvalid, tlast, tmsglast, tround,
        output tready
    );
endinterface

// File: rtl/sha2_sigma.sv
// Small sigma function of SHA-2; SIG1 picks sigma1,
// wide picks the 64-bit variant. Upper half zero when narrow.
module sha2_sigma #(
    parameter bit SIG1 = 1'b0
) (
    input  logic        wide,
    input  logic [63:0] x,
    output logic [63:0] y
);

    function automatic logic [31:0] rotr32(
        input logic [31:0] v,
        input int          n
    );
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(
        input logic [63:0] v,
        input int          n
    );
        return (v >> n) | (v << (64 - n));
    endfunction

    logic [31:0] x32;
    assign x32 = x[31:0];

    always_comb begin
        y = '0;
        if (wide) begin
            if (SIG1)
                y = rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
            else
                y = rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
        end else begin
            if (SIG1)
                y[31:0] = rotr32(x32, 17) ^ rotr32(x32, 19)
                        ^ (x32 >> 10);
            else
                y[31:0] = rotr32(x32, 7) ^ rotr32(x32, 18)
                        ^ (x32 >> 3);
        end
    end

endmodule

// File: rtl/wt_sched_gen.sv
// SHA-224/256/384/512 message schedule generator: loads one
// block, then streams W_0..W_{N-1} from a 16-word window.
module wt_sched_gen
    import sha2_pkg::*;
#(
    parameter int S_AXIS_DATA_WIDTH = 512,
    parameter int M_AXIS_DATA_WIDTH = 64,
    parameter int ROUND_W           = 7
) (
    input  logic       axi_aclk,
    input  logic       axi_resetn,
    input  logic [1:0] sha_type,
    input  logic       en,
    wt_blk_if.slave    s_axis,
    wt_word_if.master  m_axis,
    output logic       err_early_last
);

    localparam int SW    = S_AXIS_DATA_WIDTH;
    localparam int MW    = M_AXIS_DATA_WIDTH;
    localparam int WPB32 = SW / WORD_BITS_32;
    localparam int WPB64 = SW / WORD_BITS_64;
    localparam int BPB32 = BLK_BITS_32 / SW;
    localparam int BPB64 = BLK_BITS_64 / SW;

    state_e               state_q, state_d;
    logic [MW-1:0]        wbuf [BUF_WORDS];
    logic [1:0]           bcnt_q;
    logic                 mode_q;
    logic                 msglast_q;
    logic                 err_q;
    logic [ROUND_W-1:0]   t_q;

    logic                 s_ready, m_valid;
    logic                 s_hs, m_hs;
    logic                 cur_wide, last_beat, last_round;
    logic                 blk_done;
    logic [MW-1:0]        s0, s1, w_new;

    // Mode comes straight from sha_type on the first beat only.
    assign cur_wide  = (bcnt_q == 2'd0)
                     ? is_wide(sha_type_e'(sha_type)) : mode_q;
    assign last_beat = cur_wide ? (int'(bcnt_q) == BPB64 - 1)
                                : (int'(bcnt_q) == BPB32 - 1);
    assign last_round = t_q == (mode_q
                      ? ROUND_W'(ROUNDS_64 - 1)
                      : ROUND_W'(ROUNDS_32 - 1));

    assign s_ready  = (state_q == LOAD) & en & axi_resetn;
    assign m_valid  = (state_q == EMIT);
    assign s_hs     = s_ready & s_axis.tvalid;
    assign m_hs     = m_valid & m_axis.tready;
    assign blk_done = last_beat | s_axis.tlast;

    sha2_sigma #(.SIG1(1'b0)) u_sig0 (
        .wide (mode_q),
        .x    (wbuf[1]),
        .y    (s0)
    );

    sha2_sigma #(.SIG1(1'b1)) u_sig1 (
        .wide (mode_q),
        .x    (wbuf[14]),
        .y    (s1)
    );

    always_comb begin
        w_new = s1 + wbuf[9] + s0 + wbuf[0];
        if (!mode_q)
            w_new[MW-1:WORD_BITS_32] = '0;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD: if (s_hs && blk_done) state_d = EMIT;
            EMIT: if (m_hs && last_round) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn)
            state_q <= LOAD;
        else
            state_q <= state_d;
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            bcnt_q    <= '0;
            mode_q    <= 1'b0;
            msglast_q <= 1'b0;
            err_q     <= 1'b0;
            t_q       <= '0;
            for (int i = 0; i < BUF_WORDS; i++)
                wbuf[i] <= '0;
        end else begin
            if (s_hs) begin
                bcnt_q <= blk_done ? 2'd0 : bcnt_q + 2'd1;
                if (bcnt_q == 2'd0)
                    mode_q <= cur_wide;
                if (blk_done)
                    msglast_q <= s_axis.tlast;
                if (s_axis.tlast && !last_beat)
                    err_q <= 1'b1;
                // Words past a short block are zero-filled.
                for (int i = 0; i < BUF_WORDS; i++) begin
                    if (cur_wide) begin
                        if (i / WPB64 == int'(bcnt_q))
                            wbuf[i] <= MW'(s_axis.tdata[
                                SW - 1 - WORD_BITS_64 * (i % WPB64)
                                -: WORD_BITS_64]);
                        else if (i / WPB64 > int'(bcnt_q)
                                 && s_axis.tlast)
                            wbuf[i] <= '0;
                    end else begin
                        if (i / WPB32 == int'(bcnt_q))
                            wbuf[i] <= MW'(s_axis.tdata[
                                SW - 1 - WORD_BITS_32 * (i % WPB32)
                                -: WORD_BITS_32]);
                        else if (i / WPB32 > int'(bcnt_q)
                                 && s_axis.tlast)
                            wbuf[i] <= '0;
                    end
                end
            end
            if (m_hs) begin
                for (int i = 0; i < BUF_WORDS - 1; i++)
                    wbuf[i] <= wbuf[i + 1];
                wbuf[BUF_WORDS - 1] <= w_new;
                t_q <= last_round ? '0 : t_q + 1'b1;
            end
        end
    end

    assign s_axis.tready   = s_ready;
    assign m_axis.tvalid   = m_valid;
    assign m_axis.tdata    = m_valid ? wbuf[0] : '0;
    assign m_axis.tround   = t_q;
    assign m_axis.tlast    = m_valid & last_round;
    assign m_axis.tmsglast = m_valid & msglast_q;
    assign err_early_last  = err_q;

endmodule

// File: tb/tb_wt_sched_gen.sv
// Bench for wt_sched_gen: table vectors, corner sequences
// and random blocks against a recurrence-based schedule model.
module tb_wt_sched_gen;

    typedef logic [63:0] blk_t [16];
    typedef logic [63:0] sched_t [80];

    typedef struct {
        logic [1:0]  sha;
        logic [63:0] w0;
        logic [63:0] w15;
        int          tl_beat;
        logic [63:0] e_w15;
        logic [63:0] e_w16;
        logic [63:0] e_w17;
        logic [63:0] e_or8;
        int          e_n;
        bit          e_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sha_type;
    logic       en;
    logic       err;

    wt_blk_if  #(.DW(512))         s_if ();
    wt_word_if #(.DW(64), .RW(7))  m_if ();

    wt_sched_gen #(
        .S_AXIS_DATA_WIDTH (512),
        .M_AXIS_DATA_WIDTH (64),
        .ROUND_W           (7)
    ) dut (
        .axi_aclk       (clk),
        .axi_resetn     (rst_n),
        .sha_type       (sha_type),
        .en             (en),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .err_early_last (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] rx_data  [$];
    int          rx_round [$];
    bit          rx_last  [$];
    bit          rx_ml    [$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] r32(input logic [31:0] x,
                                        input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] r64(input logic [63:0] x,
                                        input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // W_t from the textbook recurrence over the full history.
    function automatic void ref_sched(input blk_t b, input bit wide,
                                      output sched_t w);
        logic [31:0] a, c;
        logic [63:0] x, y;
        for (int t = 0; t < 80; t++) w[t] = '0;
        for (int t = 0; t < 16; t++)
            w[t] = wide ? b[t] : {32'h0, b[t][31:0]};
        for (int t = 16; t < 80; t++) begin
            if (wide) begin
                x = w[t-2];
                y = w[t-15];
                w[t] = (r64(x, 19) ^ r64(x, 61) ^ (x >> 6)) + w[t-7]
                     + (r64(y, 1) ^ r64(y, 8) ^ (y >> 7)) + w[t-16];
            end else begin
                a = w[t-2][31:0];
                c = w[t-15][31:0];
                w[t] = {32'h0, (r32(a, 17) ^ r32(a, 19) ^ (a >> 10))
                     + w[t-7][31:0]
                     + (r32(c, 7) ^ r32(c, 18) ^ (c >> 3))
                     + w[t-16][31:0]};
            end
        end
    endfunction

    function automatic logic [511:0] beat_of(input blk_t b,
                                             input bit wide,
                                             input int k);
        logic [511:0] d;
        d = '0;
        if (wide)
            for (int j = 0; j < 8; j++) d[511-64*j -: 64] = b[8*k+j];
        else
            for (int j = 0; j < 16; j++) d[511-32*j -: 32] = b[j][31:0];
        return d;
    endfunction

    task automatic chk_reset_outs(input string p);
        chk({p, "_s_tready"}, 64'(s_if.tready), 64'd0);
        chk({p, "_m_tvalid"}, 64'(m_if.tvalid), 64'd0);
        chk({p, "_m_tdata"}, m_if.tdata, 64'd0);
        chk({p, "_m_tlast"}, 64'(m_if.tlast), 64'd0);
        chk({p, "_m_tround"}, 64'(m_if.tround), 64'd0);
        chk({p, "_m_tmsglast"}, 64'(m_if.tmsglast), 64'd0);
        chk({p, "_err"}, 64'(err), 64'd0);
    endtask

    task automatic send_block(input blk_t b, input bit wide,
                              input int tl_beat, input bit tl_val,
                              output bit lat_ok);
        int nb;
        int cnt;
        nb = (tl_beat >= 0) ? tl_beat + 1 : (wide ? 2 : 1);
        lat_ok = 1'b0;
        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            s_if.tdata  = beat_of(b, wide, k);
            s_if.tvalid = 1'b1;
            s_if.tlast  = (k == nb - 1)
                        ? ((tl_beat >= 0) ? 1'b1 : tl_val) : 1'b0;
            cnt = 0;
            while (!s_if.tready && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            if (cnt >= 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: beat %0d not accepted", k);
                s_if.tvalid = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        lat_ok = m_if.tvalid;
    endtask

    task automatic collect(input string nm, input int n, input int bp,
                           input int sw_at, input int ab_at,
                           output bit ab);
        int cyc, stall_bad, rdy_bad;
        bit held;
        logic [63:0] hd;
        logic [6:0]  hr;
        cyc = 0; stall_bad = 0; rdy_bad = 0; held = 0;
        hd = '0; hr = '0; ab = 0;
        rx_data.delete(); rx_round.delete();
        rx_last.delete(); rx_ml.delete();
        while (rx_data.size() < n && cyc < 2000 && !ab) begin
            @(negedge clk);
            cyc++;
            case (bp)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = cyc[0];
                default: m_if.tready = 1'($urandom_range(0, 1));
            endcase
            if (m_if.tvalid) begin
                if (s_if.tready) rdy_bad++;
                if (held && (m_if.tdata !== hd || m_if.tround !== hr))
                    stall_bad++;
                if (ab_at >= 0 && int'(m_if.tround) == ab_at) begin
                    ab = 1;
                    m_if.tready = 1'b0;
                end else if (m_if.tready) begin
                    rx_data.push_back(m_if.tdata);
                    rx_round.push_back(int'(m_if.tround));
                    rx_last.push_back(m_if.tlast);
                    rx_ml.push_back(m_if.tmsglast);
                    held = 0;
                    if (sw_at >= 0 && int'(m_if.tround) == sw_at)
                        sha_type = 2'b10;
                end else begin
                    held = 1;
                    hd = m_if.tdata;
                    hr = m_if.tround;
                end
            end
        end
        if (!ab) begin
            @(negedge clk);
            m_if.tready = 1'b0;
            chk({nm, "_tvalid_drop"}, 64'(m_if.tvalid), 64'd0);
            chk({nm, "_count"}, 64'(rx_data.size()), 64'(n));
            chk({nm, "_stall_stable"}, 64'(stall_bad), 64'd0);
            chk({nm, "_sready_in_emit"}, 64'(rdy_bad), 64'd0);
        end
    endtask

    task automatic run_blk(input string nm, input blk_t b,
                           input logic [1:0] sha, input int tl_beat,
                           input bit tl_val, input int bp,
                           input int sw_at);
        bit wide, lat, ab, ml;
        sched_t rs;
        blk_t rb;
        int n, bad, per;
        wide = sha[1];
        n = wide ? 80 : 64;
        per = wide ? 8 : 16;
        ml = tl_val || (tl_beat >= 0);
        sha_type = sha;
        send_block(b, wide, tl_beat, tl_val, lat);
        chk({nm, "_latency"}, 64'(lat), 64'd1);
        collect(nm, n, bp, sw_at, -1, ab);
        rb = b;
        if (tl_beat >= 0)
            for (int i = 0; i < 16; i++)
                if (i >= (tl_beat + 1) * per) rb[i] = '0;
        ref_sched(rb, wide, rs);
        bad = 0;
        for (int i = 0; i < rx_data.size() && i < 80; i++)
            if (rx_data[i] !== rs[i] || rx_round[i] != i
                || rx_last[i] != (i == n - 1) || rx_ml[i] != ml)
                bad++;
        chk({nm, "_seq"}, 64'(bad), 64'd0);
    endtask

    vec_t vt [5];
    blk_t b;
    blk_t abc256;
    bit   lat, ab;
    int   cnt, idx;
    logic [63:0] acc;

    initial begin
        vt[0] = '{2'b00, 64'h61626380, 64'h18, -1, 64'h18,
                  64'h61626380, 64'h000F0000, 64'h18, 64, 1'b0};
        vt[1] = '{2'b01, 64'h61626380, 64'h18, -1, 64'h18,
                  64'h61626380, 64'h000F0000, 64'h18, 64, 1'b0};
        vt[2] = '{2'b10, 64'h6162638000000000, 64'h18, -1, 64'h18,
                  64'h6162638000000000, 64'h00030000000000C0,
                  64'h18, 80, 1'b0};
        vt[3] = '{2'b11, 64'h6162638000000000, 64'h18, -1, 64'h18,
                  64'h6162638000000000, 64'h00030000000000C0,
                  64'h18, 80, 1'b0};
        vt[4] = '{2'b10, 64'h6162638000000000, 64'h18, 0, 64'h0,
                  64'h6162638000000000, 64'h0, 64'h0, 80, 1'b1};
        for (int i = 0; i < 16; i++) abc256[i] = '0;
        abc256[0]  = 64'h61626380;
        abc256[15] = 64'h18;

        rst_n = 1'b0;
        en = 1'b0;
        sha_type = 2'b00;
        s_if.tdata = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
        m_if.tready = 1'b0;
        #12;
        chk_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            for (int j = 0; j < 16; j++) b[j] = '0;
            b[0]  = vt[i].w0;
            b[15] = vt[i].w15;
            run_blk(nm, b, vt[i].sha, vt[i].tl_beat, 1'b1, 0, -1);
            chk({nm, "_w15"}, rx_data[15], vt[i].e_w15);
            chk({nm, "_w16"}, rx_data[16], vt[i].e_w16);
            chk({nm, "_w17"}, rx_data[17], vt[i].e_w17);
            acc = '0;
            for (int j = 8; j < 16; j++) acc |= rx_data[j];
            chk({nm, "_w8_15_or"}, acc, vt[i].e_or8);
            idx = -1;
            for (int j = rx_last.size() - 1; j >= 0; j--)
                if (rx_last[j]) idx = j;
            chk({nm, "_tlast_at"}, 64'(idx), 64'(vt[i].e_n - 1));
            chk({nm, "_err"}, 64'(err), 64'(vt[i].e_err));
        end

        run_blk("bp", abc256, 2'b00, -1, 1'b1, 1, -1);
        chk("bp_w17", rx_data[17], 64'h000F0000);

        run_blk("b2b_a", abc256, 2'b00, -1, 1'b0, 0, 5);
        for (int j = 0; j < 16; j++) b[j] = {32'h0, $urandom};
        run_blk("b2b_b", b, 2'b00, -1, 1'b1, 0, -1);
        chk("b2b_err_held", 64'(err), 64'd1);

        for (int r = 0; r < 6; r++) begin
            logic [1:0] st;
            st = 2'($urandom_range(0, 3));
            for (int j = 0; j < 16; j++) b[j] = {$urandom, $urandom};
            run_blk($sformatf("rnd%0d", r), b, st, -1,
                    1'($urandom_range(0, 1)), 2, -1);
        end

        sha_type = 2'b00;
        send_block(abc256, 1'b0, -1, 1'b1, lat);
        collect("rst", 64, 0, -1, 30, ab);
        chk("rst_reached_r30", 64'(ab), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_async");
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (s_if.tready) cnt++;
        end
        chk("rst_ready_en0", 64'(cnt), 64'd0);
        en = 1'b1;
        run_blk("rst_abc", abc256, 2'b00, -1, 1'b1, 0, -1);
        chk("rst_abc_w16", rx_data[16], 64'h61626380);
        chk("rst_abc_err", 64'(err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wt_sched_gen.md
Name: wt_sched_gen

Overview:
- Parametrised SHA-2 message-schedule generator, successor to the fixed SHA-256 W_t unit.
- Accepts one padded message block over AXI4-Stream as one or more beats. Supports SHA-224/256 (32-bit words, 512-bit block, 64 rounds) and SHA-384/512 (64-bit words, 1024-bit block, 80 rounds).
- Emits W_0..W_{N-1} one word per handshake to the compression core over a master stream.
- Sits between the padder/scheduler and the hash round engine.

Parameters:
- S_AXIS_DATA_WIDTH, 512, slave beat width; legal values 256 or 512.
- M_AXIS_DATA_WIDTH, 64, master word width; fixed at 64. In 32-bit mode W occupies [31:0] and [63:32] is zero.
- ROUND_W, 7, width of the round-index sideband.

Ports:
- axi_aclk  in  1  clock
- axi_resetn  in  1  asynchronous active-low reset
- sha_type  in  2  00=SHA256, 01=SHA224, 10=SHA512, 11=SHA384; bit1=1 selects 64-bit mode
- en  in  1  engine enabled by scheduler
- s_axis_tdata  in  S_AXIS_DATA_WIDTH  block beat; big-endian, word 0 in MSBs of first beat
- s_axis_tvalid  in  1  slave valid
- s_axis_tready  out  1  slave ready
- s_axis_tlast  in  1  beat is the last beat of the message
- m_axis_tdata  out  64  W_t
- m_axis_tvalid  out  1  master valid
- m_axis_tready  in  1  master ready
- m_axis_tlast  out  1  final round (N-1) of current block
- m_axis_tround  out  ROUND_W  round index t
- m_axis_tmsglast  out  1  current block is the last block of the message
- err_early_last  out  1  sticky: tlast seen before block complete

Behaviour:
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tround=0, m_axis_tmsglast=0, err_early_last=0. State=LOAD; word buffer cleared.
- Reset mid-operation discards the block in progress. s_axis_tready may rise in the first cycle after axi_resetn deasserts, provided en=1.
- State LOAD:
  - s_axis_tready = en.
  - sha_type is latched as mode on the first beat handshake of a block. Later changes are ignored until the next block.
  - Beats per block B = blockbits/S_AXIS_DATA_WIDTH, giving 1, 2 or 4.
  - Each handshake writes S_AXIS_DATA_WIDTH/wordbits words into a 16-entry x 64-bit buffer, in order.
  - After beat B: s_axis_tlast is latched into msglast and the state goes to EMIT.
- Early tlast: a tlast handshake on beat k<B zero-fills the remaining words, sets err_early_last (cleared only by reset), and goes to EMIT.
- State EMIT:
  - s_axis_tready=0.
  - m_axis_tvalid=1 from the cycle after the final beat handshake. Latency from last beat to W_0 valid is 1 cycle.
  - m_axis_tdata = buf[0] (masked to 32 bits in 32-bit mode).
  - m_axis_tround = t.
  - m_axis_tlast = (t==N-1).
  - m_axis_tmsglast = msglast.
- On each master handshake:
  - buf[i] <= buf[i+1] for i=0..14.
  - buf[15] <= sigma1(buf[14]) + buf[9] + sigma0(buf[1]) + buf[0], modulo 2^wordbits.
  - t <= t+1.
  - Steady-state throughput is 1 word/cycle.
- Stall (tvalid=1, tready=0): every master output holds stable; no word is skipped or duplicated.
- Handshake at t=N-1: m_axis_tvalid drops, t resets to 0, state returns to LOAD, and s_axis_tready is driven by en from the next cycle. Block loads do not overlap emission.
- en low: in LOAD no new beats are accepted. In EMIT the current block completes.
- Sigma functions, 32-bit mode:
  - sigma0 = ROTR7 ^ ROTR18 ^ SHR3
  - sigma1 = ROTR17 ^ ROTR19 ^ SHR10
- Sigma functions, 64-bit mode:
  - sigma0 = ROTR1 ^ ROTR8 ^ SHR7
  - sigma1 = ROTR19 ^ ROTR61 ^ SHR6
- In 32-bit mode every buffer word is kept zero in bits [63:32].
- SHA224/384 schedules are identical to SHA256/512 respectively.

Decomposition:
- Package sha2_pkg holds:
  - sha_type encodings
  - round counts (64/80)
  - block widths (512/1024)
  - word widths
  - LOAD/EMIT state encoding
- One sub-module, sha2_sigma: combinational sigma0/sigma1 with a mode input. It is instantiated once for each function.

Test Plan:
1. SHA256 "abc" padded block (W0=0x61626380, W15=0x18), one 512-bit beat with tlast=1 -> 64 outputs.
   - Required: W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000.
   - tlast only at tround=63; tmsglast=1; upper 32 bits always 0.
2. SHA512 "abc" block (W0=0x6162638000000000, W15=0x18), two 512-bit beats -> 80 outputs.
   - Required: W16=0x6162638000000000, W17=0x00030000000000C0.
   - tlast at tround=79.
3. Backpressure: m_axis_tready toggles 1,0,1,0 during SHA256 "abc".
   - Required: tdata/tround stable while stalled, 64 distinct consecutive rounds, values identical to scenario 1.
4. Two back-to-back SHA256 blocks, tlast only on the second; sha_type switched to 10 during the first emission.
   - Required: both blocks run 64 rounds; tmsglast=0 then 1; s_axis_tready=0 throughout EMIT.
5. SHA512 block with tlast on beat 0 of 2 (S_AXIS_DATA_WIDTH=512).
   - Required: W8..W15=0, err_early_last=1 and held, 80 rounds emitted.
6. Reset asserted at round 30; en=0 after release.
   - Required: all outputs return to reset values immediately (async); s_axis_tready stays 0 until en=1, then a fresh "abc" block reproduces scenario 1.
